// File: rtl/pipe_stage_skid_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_skid_reg
//
// Pipeline-stage register (IF/ID, ID/EX, ...) with a valid/ready handshake.
// A 2-entry skid buffer is used, so in_ready depends only on the state
// register and there is no combinational path from out_ready to in_ready.
// A flush loads a bubble. An occupancy output and a saturating stall
// counter are also provided.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   upstream payload valid
//   in_ready   stage can accept a payload (state-derived)
//   in_data    upstream payload
//   out_valid  stage holds a valid payload (state-derived)
//   out_ready  downstream accepts the payload
//   out_data   payload to downstream; BUBBLE_VAL when out_valid=0
//   flush      synchronous flush: drop all entries, insert a bubble
//   clr_stats  synchronous clear of stall_cnt
//   occupancy  number of entries held (0, 1 or 2)
//   stall_cnt  cycles with out_valid=1 and out_ready=0, saturating
// ----------------------------------------------------------------------------
module pipe_stage_skid_reg #(
    parameter int                DATA_W     = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              clr_stats,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_q;  // head entry, drives out_data
    logic [DATA_W-1:0] skid_q;  // second entry, meaningful only in FULL

    logic in_fire;
    logic out_fire;

    // Handshake outputs come from the state register alone, which keeps
    // out_ready from reaching in_ready combinationally.
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);
    assign out_data  = main_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        // NOTE: default first so every path assigns occupancy; no latch.
        occupancy = 2'd0;
        case (state)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    // NOTE: the payload registers are reset as well as the state, because
    // out_data must show BUBBLE_VAL whenever the stage is empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= EMPTY;
            main_q <= BUBBLE_VAL;
            skid_q <= BUBBLE_VAL;
        end else if (flush) begin
            // An out_fire in this cycle still completes downstream; any
            // in_fire payload is dropped.
            state  <= EMPTY;
            main_q <= BUBBLE_VAL;
            skid_q <= BUBBLE_VAL;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state  <= ONE;
                        main_q <= in_data;
                    end
                end
                ONE: begin
                    case ({in_fire, out_fire})
                        2'b11: main_q <= in_data;
                        2'b10: begin
                            state  <= FULL;
                            skid_q <= in_data;
                        end
                        2'b01: begin
                            state  <= EMPTY;
                            main_q <= BUBBLE_VAL;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    // in_ready is low here, so only the drain case exists.
                    if (out_fire) begin
                        state  <= ONE;
                        main_q <= skid_q;
                        skid_q <= BUBBLE_VAL;
                    end
                end
                default: begin
                    state  <= EMPTY;
                    main_q <= BUBBLE_VAL;
                    skid_q <= BUBBLE_VAL;
                end
            endcase
        end
    end

    // Back-pressure counter: independent of flush, clear wins over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (clr_stats) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_skid_reg
//
// Bench for pipe_stage_skid_reg (DATA_W=64, CNT_W=4). A queue-based model
// holds the payloads the stage should contain. Every falling edge compares
// all DUT outputs against it. Directed sequences add literal expectations,
// and a random handshake phase stresses ordering and back-pressure.
// ----------------------------------------------------------------------------
module tb_pipe_stage_skid_reg;

    localparam int DATA_W  = 64;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic              clr_stats;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int tests = 0;
    int fails = 0;

    pipe_stage_skid_reg #(
        .DATA_W    (DATA_W),
        .BUBBLE_VAL({DATA_W{1'b0}}),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .flush    (flush),
        .clr_stats(clr_stats),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: a queue of held payloads -----------
    logic [DATA_W-1:0] mq[$];
    int                m_stall = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_stall <= 0;
        end else begin
            if (clr_stats)
                m_stall <= 0;
            else if (mq.size() > 0 && !out_ready && m_stall < CNT_MAX)
                m_stall <= m_stall + 1;

            if (flush) begin
                mq.delete();
            end else if (mq.size() == 0) begin
                if (in_valid) mq.push_back(in_data);
            end else if (mq.size() == 1) begin
                if (out_ready) void'(mq.pop_front());
                if (in_valid)  mq.push_back(in_data);
            end else begin
                if (out_ready) void'(mq.pop_front());
            end
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        logic [DATA_W-1:0] exp_data;
        exp_data = '0;
        if (mq.size() > 0) exp_data = mq[0];
        check("m_out_valid", 64'(out_valid), 64'(mq.size() != 0));
        check("m_in_ready",  64'(in_ready),  64'(mq.size() < 2));
        check("m_occupancy", 64'(occupancy), 64'(mq.size()));
        check("m_out_data",  out_data,       exp_data);
        check("m_stall_cnt", 64'(stall_cnt), 64'(m_stall));
    end

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        clr_stats = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        in_valid = 1'b1;            // ignored while in reset
        in_data  = 64'hDEAD;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  out_data,       64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        cyc();
        cyc();
        check("rst_ignore_in", 64'(out_valid), 64'd0);
        rst = 1'b1;

        // ---- streaming: 1-cycle latency, 1 word per cycle -------------
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 64'h0000_0004_0050_0093;
        cyc();
        check("lat_out_valid", 64'(out_valid), 64'd1);
        check("lat_out_data",  out_data,       64'h0000_0004_0050_0093);
        check("lat_occupancy", 64'(occupancy), 64'd1);
        in_data = 64'h11;
        cyc();
        check("stream_w1", out_data, 64'h11);
        in_data = 64'h22;
        cyc();
        check("stream_w2", out_data, 64'h22);
        check("stream_occ", 64'(occupancy), 64'd1);
        in_valid = 1'b0;
        cyc();
        check("stream_drained", 64'(out_valid), 64'd0);

        // ---- fill to FULL under back-pressure, then drain --------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h1;
        cyc();
        check("fill_occ1", 64'(occupancy), 64'd1);
        in_data = 64'h2;
        cyc();
        check("fill_occ2",      64'(occupancy), 64'd2);
        check("fill_in_ready",  64'(in_ready),  64'd0);
        check("fill_head_A",    out_data,       64'h1);
        in_valid = 1'b0;
        cyc();
        check("fill_stable_A",  out_data,       64'h1);
        out_ready = 1'b1;
        cyc();
        check("drain_B",        out_data,       64'h2);
        check("drain_occ1",     64'(occupancy), 64'd1);
        cyc();
        check("drain_occ0",     64'(occupancy), 64'd0);
        check("drain_bubble",   out_data,       64'd0);

        // ---- flush from FULL with a simultaneous in_valid ---------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA;
        cyc();
        in_data = 64'hB;
        cyc();
        check("pre_flush_occ", 64'(occupancy), 64'd2);
        flush   = 1'b1;
        in_data = 64'h3;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_occ",       64'(occupancy), 64'd0);
        check("flush_out_data",  out_data,       64'd0);
        check("flush_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        cyc();
        check("flush_no_3", 64'(out_valid), 64'd0);

        // ---- stall counter: count, saturate, clear ----------------------
        clr_stats = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h5;
        cyc();
        clr_stats = 1'b0;
        in_valid  = 1'b0;
        check("stall_start", 64'(stall_cnt), 64'd0);
        repeat (10) cyc();
        check("stall_10", 64'(stall_cnt), 64'd10);
        repeat (10) cyc();
        check("stall_sat", 64'(stall_cnt), 64'd15);
        clr_stats = 1'b1;
        cyc();
        clr_stats = 1'b0;
        check("stall_clr", 64'(stall_cnt), 64'd0);
        cyc();
        check("stall_resume", 64'(stall_cnt), 64'd1);
        check("stall_hold_data", out_data, 64'h5);
        out_ready = 1'b1;
        cyc();

        // ---- asynchronous reset while in ONE ----------------------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h7;
        cyc();
        in_valid = 1'b0;
        check("arst_pre_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_data",  out_data,       64'd0);
        check("arst_occ",       64'(occupancy), 64'd0);
        check("arst_in_ready",  64'(in_ready),  64'd1);
        cyc();
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 64'h9;
        cyc();
        check("arst_after_xfer", out_data, 64'h9);
        in_valid = 1'b0;
        cyc();

        // ---- random handshake, 50% density -----------------------------
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = {$urandom, $urandom};
            cyc();
        end
        idle_inputs();
        out_ready = 1'b1;
        repeat (3) cyc();
        check("final_empty", 64'(occupancy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised pipeline-stage register for the processor pipeline (IF/ID, ID/EX, ...) with a valid/ready handshake in place of a plain write-enable.
- A 2-entry skid buffer keeps in_ready purely state-derived, so there is no combinational path from out_ready to in_ready.
- Adds a synchronous flush that inserts a bubble, an occupancy output and a saturating back-pressure (stall) counter.

Parameters:
DATA_W, 64, payload width (e.g. {PC[31:0], instruction[31:0]})
BUBBLE_VAL, {DATA_W{1'b0}}, payload loaded on reset, flush and drain (all-zero instruction = bubble)
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept a payload
in_data  input  DATA_W  upstream payload
out_valid  output  1  stage holds a valid payload
out_ready  input  1  downstream accepts payload
out_data  output  DATA_W  payload to downstream
flush  input  1  synchronous flush/bubble insert
clr_stats  input  1  synchronous clear of stall_cnt
occupancy  output  2  entries held: 0, 1 or 2
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Handshake events:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Storage:
  - main register drives out_data.
  - skid register is used only in state FULL.
- States and derived outputs:
  - EMPTY (occupancy 0), ONE (occupancy 1), FULL (occupancy 2).
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
  - Both are decoded from the state register only.
- Reset (rst=0, asynchronous):
  - state=EMPTY, main=skid=BUBBLE_VAL, stall_cnt=0.
  - Outputs: out_valid=0, out_data=BUBBLE_VAL, occupancy=0, in_ready=1.
  - Any in_valid while rst=0 is ignored.
- Transitions (evaluated each rising edge, no flush):
  - EMPTY: in_fire -> ONE, main<=in_data.
  - ONE, in_fire & out_fire -> ONE, main<=in_data.
  - ONE, in_fire only -> FULL, skid<=in_data.
  - ONE, out_fire only -> EMPTY, main<=BUBBLE_VAL.
  - ONE, neither -> hold.
  - FULL: out_fire -> ONE, main<=skid, skid<=BUBBLE_VAL. in_fire is impossible (in_ready=0).
- Latency:
  - 1 cycle from in_fire to out_valid when the stage is empty.
  - FIFO ordering is always preserved; no payload is dropped or duplicated without flush.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid must not change.
- Bubble invariant: out_data = BUBBLE_VAL whenever out_valid=0.
- flush=1 at an edge:
  - state<=EMPTY, main<=skid<=BUBBLE_VAL.
  - A simultaneous in_fire payload is discarded.
  - A simultaneous out_fire still completes; the downstream owns that payload.
  - Next cycle: out_valid=0, in_ready=1.
- Priority: rst > flush > normal transitions.
- stall_cnt:
  - Increments by 1 on each edge where out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - clr_stats=1 loads 0 and takes priority over the increment.
  - Unaffected by flush.
- Reset asserted mid-operation: all held payloads are lost immediately; outputs take their reset values asynchronously, without waiting for a clock edge.

Test Plan:
- Reset, then in_valid=1, in_data=64'h0000_0004_0050_0093, out_ready=1 -> next cycle out_valid=1, out_data=64'h0000_0004_0050_0093, occupancy=1; continuous streaming of 3 words gives 1 word per cycle in order.
- Fill with out_ready=0: send A=64'h1, B=64'h2 on consecutive cycles -> occupancy=2, in_ready=0, out_data=A held stable; raise out_ready -> A then B delivered on consecutive cycles, occupancy 2->1->0, out_data=0 after drain.
- From FULL (A, B held), assert flush with in_valid=1, in_data=64'h3 -> next cycle out_valid=0, occupancy=0, out_data=BUBBLE_VAL, in_ready=1; 64'h3 never appears at the output.
- Hold out_valid=1, out_ready=0 for 10 cycles with CNT_W=4 -> stall_cnt=10; hold 20 cycles -> stall_cnt=15 (saturated); clr_stats=1 for one cycle while still stalled -> stall_cnt=0, then resumes counting at 1.
- Assert rst=0 between clock edges while in state ONE -> out_valid=0, out_data=BUBBLE_VAL, occupancy=0 before the next edge; release rst -> a normal transfer works.
- Random in_valid/out_ready (10k cycles, 50% density) against a scoreboard queue -> output sequence equals input sequence, out_data stable under back-pressure, occupancy never exceeds 2, no in_fire while occupancy=2.
